// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: MMIO offsets,
// the store-log entry layout and the address decoder.
package dmem_pkg;

    localparam logic [31:0] DONE_OFS   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } log_entry_t;

    typedef enum logic [1:0] {
        DEC_RAM    = 2'd0,
        DEC_DONE   = 2'd1,
        DEC_STATUS = 2'd2,
        DEC_NONE   = 2'd3
    } dec_e;

    // Classifies a word-aligned byte address into the region it selects.
    function automatic dec_e decode(input logic [31:0] wadr,
                                    input logic [31:0] mmio_base,
                                    input logic [31:0] ram_bytes);
        dec_e dec;
        if (wadr < ram_bytes) begin
            dec = DEC_RAM;
        end else if (wadr == mmio_base + DONE_OFS) begin
            dec = DEC_DONE;
        end else if (wadr == mmio_base + STATUS_OFS) begin
            dec = DEC_STATUS;
        end else begin
            dec = DEC_NONE;
        end
        return dec;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-facing store/load bus plus the store-log drain port of dmem_responder.
interface dmem_responder_if;
    logic        mem_write_pi;
    logic [31:0] data_adr_pi;
    logic [31:0] write_data_pi;
    logic [31:0] read_data_po;
    logic        log_valid_po;
    logic        log_ready_pi;
    logic [31:0] log_adr_po;
    logic [31:0] log_data_po;
    logic        done_po;
    logic [31:0] done_value_po;
    logic        err_po;
    logic        overflow_po;

    modport master (
        output mem_write_pi, data_adr_pi, write_data_pi, log_ready_pi,
        input  read_data_po, log_valid_po, log_adr_po, log_data_po,
               done_po, done_value_po, err_po, overflow_po
    );

    modport slave (
        input  mem_write_pi, data_adr_pi, write_data_pi, log_ready_pi,
        output read_data_po, log_valid_po, log_adr_po, log_data_po,
               done_po, done_value_po, err_po, overflow_po
    );
endinterface

// File: rtl/dmem_responder_sync_fifo.sv
// Synchronous FIFO with extra pointer bit to tell full from empty; head is
// presented combinationally from the storage array.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int             PW        = $clog2(DEPTH);
    localparam logic [PW:0]    PTR_ONE   = (PW+1)'(1);
    localparam logic [PW:0]    DEPTH_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == DEPTH_CNT);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

    // Pointer advance; a push into a full FIFO without a pop is ignored.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && (!full_o || pop_i)) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, written at the tail when the push is taken.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i && (!full_o || pop_i)) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM (async read, sync write), DONE/STATUS MMIO
// registers, sticky error flags and a store log drained over valid/ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
    parameter int          LOG_DEPTH = 8,
    parameter string       INIT_FILE = ""
) (
    input logic            clk_pi,
    input logic            reset_pi,
    dmem_responder_if.slave bus
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          CW        = $clog2(LOG_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0] ram_q [RAM_WORDS];

    logic [31:0] wadr_s;
    dec_e        dec_s;
    logic        accept_s, reject_s, ram_we_s;
    logic        push_s, pop_s, full_s, empty_s;
    logic [CW-1:0] count_s;
    log_entry_t  head_s, new_entry_s;

    logic        done_q, done_d;
    logic [31:0] done_value_q, done_value_d;
    logic        err_q, err_d;
    logic        overflow_q, overflow_d;

    // Low address bits are ignored for decode; stores additionally require them zero.
    assign wadr_s = {bus.data_adr_pi[31:2], 2'b00};
    assign dec_s  = decode(wadr_s, MMIO_BASE, RAM_BYTES);

    // Store classification and log push/pop handshake.
    always_comb begin
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        if (!reset_pi && bus.mem_write_pi) begin
            accept_s = (bus.data_adr_pi[1:0] == 2'b00) &&
                       ((dec_s == DEC_RAM) || (dec_s == DEC_DONE));
            reject_s = !accept_s;
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
        ram_we_s    = accept_s && (dec_s == DEC_RAM);
        pop_s       = !empty_s && bus.log_ready_pi;
        push_s      = accept_s && (!full_s || pop_s);
        new_entry_s = '{adr: bus.data_adr_pi, data: bus.write_data_pi};
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk_pi) begin
        if (ram_we_s) begin
            ram_q[bus.data_adr_pi[AW+1:2]] <= bus.write_data_pi;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(log_entry_t)),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk_i   (clk_pi),
        .rst_i   (reset_pi),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (new_entry_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Sticky flag next-state: first DONE store wins, errors and drops latch.
    always_comb begin
        done_d       = done_q;
        done_value_d = done_value_q;
        err_d        = err_q | reject_s;
        overflow_d   = overflow_q | (accept_s && full_s && !pop_s);
        if (accept_s && (dec_s == DEC_DONE) && !done_q) begin
            done_d       = 1'b1;
            done_value_d = bus.write_data_pi;
        end else begin
            done_d       = done_q;
            done_value_d = done_value_q;
        end
    end

    // Sticky flag registers.
    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            done_q       <= 1'b0;
            done_value_q <= 32'h0000_0000;
            err_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            done_q       <= done_d;
            done_value_q <= done_value_d;
            err_q        <= err_d;
            overflow_q   <= overflow_d;
        end
    end

    // Combinational load mux for the single-cycle core.
    always_comb begin
        bus.read_data_po = 32'h0000_0000;
        case (dec_s)
            DEC_RAM:    bus.read_data_po = ram_q[bus.data_adr_pi[AW+1:2]];
            DEC_DONE:   bus.read_data_po = {31'b0, done_q};
            DEC_STATUS: bus.read_data_po = {16'b0, 8'(count_s), 5'b0,
                                            overflow_q, err_q, !empty_s};
            default:    bus.read_data_po = 32'h0000_0000;
        endcase
    end

    assign bus.log_valid_po  = !empty_s;
    assign bus.log_adr_po    = head_s.adr;
    assign bus.log_data_po   = head_s.data;
    assign bus.done_po       = done_q;
    assign bus.done_value_po = done_value_q;
    assign bus.err_po        = err_q;
    assign bus.overflow_po   = overflow_q;
endmodule
